// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the time-shared symmetric FIR scheduler.
package fir_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int unsigned NTAPS = 8;
   localparam int unsigned NUNIQ = 4;

   localparam int DEF_COE [NUNIQ] = '{26, 129, 316, 478};

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational grant, pointer advances past the winner on accept.
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned PW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_accept,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_grant_idx,
   output logic          o_grant_valid
);

   logic [PW-1:0] r_ptr;
   logic          w_found;
   logic [PW-1:0] w_idx;
   int            w_dist;
   int            w_best;

   // Winner is the requester at the smallest wrap-around distance from the pointer.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_best  = int'(N);
      w_dist  = 0;
      for (int j = 0; j < int'(N); j++) begin
         w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + int'(N) - int'(r_ptr));
         if (i_req[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_found = 1'b1;
            w_idx   = PW'(j);
         end
      end
   end

   always_comb begin
      o_grant = '0;
      if (w_found) o_grant[w_idx] = 1'b1;
   end

   assign o_grant_idx   = w_idx;
   assign o_grant_valid = w_found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if (i_accept)
         r_ptr <= (int'(w_idx) == int'(N) - 1) ? '0 : w_idx + PW'(1);
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shared 8-tap symmetric FIR controller: per-channel delay lines, one pre-add/MAC
// sequenced over 4 unique coefficients, shadow coefficient bank committed at sample boundaries.
module fir_mac_scheduler
   import fir_sched_pkg::*;
#(
   parameter int unsigned NCH = 2,
   parameter int unsigned DW  = 12,
   parameter int unsigned CW  = 10,
   parameter int unsigned OW  = 25,
   parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    s_valid,
   input  logic [NCH*DW-1:0] s_data,
   output logic [NCH-1:0]    s_ready,
   output logic              m_valid,
   output logic [OW-1:0]     m_data,
   output logic [CHW-1:0]    m_ch,
   input  logic              m_ready,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [CW-1:0]     cfg_data,
   input  logic              cfg_commit,
   output logic              busy
);

   state_t                r_state;
   logic [1:0]            r_k;
   logic [CHW-1:0]        r_ch;
   logic signed [OW-1:0]  r_acc;
   logic                  r_commit_pend;
   logic signed [DW-1:0]  r_line    [NCH][NTAPS];
   logic signed [CW-1:0]  r_coe_act [NUNIQ];
   logic signed [CW-1:0]  r_coe_shd [NUNIQ];

   logic [NCH-1:0]        w_grant;
   logic [CHW-1:0]        w_grant_idx;
   logic                  w_grant_valid;
   logic                  w_accept;
   logic signed [DW-1:0]  w_sample;
   logic signed [DW-1:0]  w_xa;
   logic signed [DW-1:0]  w_xb;
   logic signed [CW-1:0]  w_coe;
   logic signed [DW:0]    w_pre;
   logic signed [DW+CW:0] w_prod;

   rr_arbiter #(.N(NCH), .PW(CHW)) u_arb (
      .clk           (clk),
      .rst           (rst),
      .i_req         (s_valid),
      .i_accept      (w_accept),
      .o_grant       (w_grant),
      .o_grant_idx   (w_grant_idx),
      .o_grant_valid (w_grant_valid)
   );

   assign w_accept = (r_state == IDLE) && w_grant_valid;
   assign s_ready  = (r_state == IDLE) ? w_grant : '0;
   assign busy     = (r_state != IDLE);

   always_comb begin
      w_sample = '0;
      for (int c = 0; c < int'(NCH); c++)
         if (w_grant[c]) w_sample = s_data[c*DW +: DW];
   end

   // Symmetric pair for step k: taps k and 7-k of the accepted channel only.
   assign w_xa   = r_line[r_ch][{1'b0, r_k}];
   assign w_xb   = r_line[r_ch][3'd7 - {1'b0, r_k}];
   assign w_coe  = r_coe_act[r_k];
   assign w_pre  = (DW+1)'(w_xa) + (DW+1)'(w_xb);
   assign w_prod = (DW+CW+1)'(w_pre) * (DW+CW+1)'(w_coe);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_k           <= '0;
         r_ch          <= '0;
         r_acc         <= '0;
         r_commit_pend <= 1'b0;
         m_valid       <= 1'b0;
         m_data        <= '0;
         m_ch          <= '0;
         for (int c = 0; c < int'(NCH); c++)
            for (int t = 0; t < int'(NTAPS); t++)
               r_line[c][t] <= '0;
         for (int k = 0; k < int'(NUNIQ); k++) begin
            r_coe_act[k] <= CW'(DEF_COE[k]);
            r_coe_shd[k] <= CW'(DEF_COE[k]);
         end
      end else begin
         if (cfg_we) r_coe_shd[cfg_addr] <= cfg_data;

         // A new commit request outranks the clear so it is never dropped.
         if (cfg_commit)
            r_commit_pend <= 1'b1;
         else if ((r_state == IDLE) && r_commit_pend)
            r_commit_pend <= 1'b0;

         case (r_state)
            IDLE: begin
               if (r_commit_pend)
                  for (int k = 0; k < int'(NUNIQ); k++)
                     r_coe_act[k] <= r_coe_shd[k];
               if (w_accept) begin
                  for (int c = 0; c < int'(NCH); c++) begin
                     if (w_grant[c]) begin
                        for (int t = int'(NTAPS) - 1; t > 0; t--)
                           r_line[c][t] <= r_line[c][t-1];
                        r_line[c][0] <= w_sample;
                     end
                  end
                  r_ch    <= w_grant_idx;
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               r_acc <= r_acc + OW'(w_prod);
               r_k   <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  m_valid <= 1'b1;
                  m_data  <= r_acc + OW'(w_prod);
                  m_ch    <= r_ch;
                  r_state <= OUT;
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: transaction-level reference model checked every cycle,
// directed scenarios pinned with literal results, then randomized traffic.
module tb_fir_mac_scheduler;

   localparam int NCH = 2;
   localparam int DW  = 12;
   localparam int CW  = 10;
   localparam int OW  = 25;
   localparam int CHW = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    s_valid;
   logic [NCH*DW-1:0] s_data;
   logic [NCH-1:0]    s_ready;
   logic              m_valid;
   logic [OW-1:0]     m_data;
   logic [CHW-1:0]    m_ch;
   logic              m_ready;
   logic              cfg_we;
   logic [1:0]        cfg_addr;
   logic [CW-1:0]     cfg_data;
   logic              cfg_commit;
   logic              busy;
   logic [DW-1:0]     din [NCH];

   assign s_data = {din[1], din[0]};

   fir_mac_scheduler #(.NCH(NCH), .DW(DW), .CW(CW), .OW(OW), .CHW(CHW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch), .m_ready(m_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   int mline [NCH][8];
   int mact [4];
   int mshd [4];
   bit mpend, mbusy, mv;
   int mcnt, mptr, mexp, mch, mg;
   int acc_t [$];
   int acc_c [$];
   int cap_d [$];
   int cap_c [$];
   int t1_exp [9] = '{26000, 129000, 316000, 478000, 478000, 316000, 129000, 26000, 0};

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NCH-1:0] v);
      for (int i = 0; i < NCH; i++) begin
         int c;
         c = (mptr + i) % NCH;
         if (((int'(v) >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < 8; t++) mline[c][t] = 0;
      mact  = '{26, 129, 316, 478};
      mshd  = '{26, 129, 316, 478};
      mpend = 0; mbusy = 0; mv = 0;
      mcnt  = 0; mptr = 0; mexp = 0; mch = 0;
   endtask

   // Sample-level model: one result per accepted sample, 5 cycles later, held until taken.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         cyc++;
         if (mv) begin
            if (m_ready) begin mv = 0; mbusy = 0; end
         end else if (mbusy) begin
            mcnt++;
            if (mcnt == 5) mv = 1;
         end else begin
            if (mpend) begin mact = mshd; mpend = 0; end
            mg = pick(s_valid);
            if (mg >= 0) begin
               for (int t = 7; t > 0; t--) mline[mg][t] = mline[mg][t-1];
               mline[mg][0] = int'($signed(s_data[mg*DW +: DW]));
               mexp = 0;
               for (int k = 0; k < 4; k++)
                  mexp += (mline[mg][k] + mline[mg][7-k]) * mact[k];
               mch   = mg;
               mbusy = 1;
               mcnt  = 1;
               mptr  = (mg + 1) % NCH;
               acc_t.push_back(cyc);
               acc_c.push_back(mg);
            end
         end
         if (cfg_we) mshd[cfg_addr] = int'($signed(cfg_data));
         if (cfg_commit) mpend = 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         int g;
         logic [NCH-1:0] exp_ready;
         g = pick(s_valid);
         exp_ready = (mbusy || g < 0) ? '0 : NCH'(1 << g);
         chk("s_ready", longint'(s_ready), longint'(exp_ready));
         chk("busy", longint'(busy), longint'(mbusy));
         chk("m_valid", longint'(m_valid), longint'(mv));
         if (mv) begin
            chk("m_data", longint'($signed(m_data)), longint'(mexp));
            chk("m_ch", longint'(m_ch), longint'(mch));
         end
         if (m_valid && m_ready) begin
            cap_d.push_back(int'($signed(m_data)));
            cap_c.push_back(int'(m_ch));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; s_valid = '0; cfg_we = 1'b0; cfg_commit = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      cap_d.delete(); cap_c.delete(); acc_t.delete(); acc_c.delete();
   endtask

   task automatic send(input int ch, input int v);
      bit done;
      done = 0;
      din[ch] = DW'(v);
      s_valid[ch] = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (s_ready[ch]) begin
            @(posedge clk); #1;
            s_valid[ch] = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         chk("send_timeout", 0, 1);
         s_valid[ch] = 1'b0;
      end
   endtask

   task automatic wait_caps(input int n);
      for (int t = 0; t < 300 && cap_d.size() < n; t++) @(posedge clk);
      #1;
      if (cap_d.size() < n) chk("output_timeout", cap_d.size(), n);
      while (cap_d.size() < n) begin cap_d.push_back(0); cap_c.push_back(0); end
   endtask

   task automatic wr_cfg(input int addr, input int val, input bit commit);
      cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = CW'(val); cfg_commit = commit;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_commit = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; s_valid = '0; din[0] = '0; din[1] = '0; m_ready = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_ch", m_ch, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // 1: impulse response on ch0
      send(0, 1000);
      for (int i = 0; i < 8; i++) send(0, 0);
      wait_caps(9);
      for (int i = 0; i < 9; i++) begin
         chk("t1_data", cap_d[i], t1_exp[i]);
         chk("t1_ch", cap_c[i], 0);
      end

      // 2: both channels streaming, alternating grants at 6-cycle spacing
      do_reset();
      din[0] = DW'(100); din[1] = DW'(-5); s_valid = 2'b11;
      for (int n = 0; n < 300 && acc_t.size() < 16; n++) begin @(posedge clk); #1; end
      s_valid = '0;
      chk("t2_accepts", acc_t.size(), 16);
      wait_caps(16);
      for (int i = 1; i < 16 && i < acc_t.size(); i++) begin
         chk("t2_gap", acc_t[i] - acc_t[i-1], 6);
         chk("t2_grant", acc_c[i], i % 2);
      end
      chk("t2_ch0_dc", cap_d[14], 189800);
      chk("t2_ch1_dc", cap_d[15], -9490);

      // 3: backpressure holds the result and blocks new accepts
      do_reset();
      m_ready = 1'b0;
      send(0, 300);
      for (int n = 0; n < 20 && !m_valid; n++) begin @(posedge clk); #1; end
      din[1] = DW'(77); s_valid[1] = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk("t3_valid", m_valid, 1);
         chk("t3_data", $signed(m_data), 7800);
         chk("t3_ch", m_ch, 0);
         chk("t3_sready", s_ready, 0);
         chk("t3_busy", busy, 1);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      send(1, 77);
      wait_caps(2);
      chk("t3_first", cap_d[0], 7800);
      chk("t3_late", cap_d[1], 2002);
      chk("t3_late_ch", cap_c[1], 1);

      // 4: commit during MAC affects only the following sample
      do_reset();
      for (int i = 0; i < 8; i++) send(0, 10);
      send(0, 10);
      for (int k = 0; k < 4; k++) wr_cfg(k, k + 1, k == 3);
      send(0, 10);
      wait_caps(10);
      chk("t4_inflight", cap_d[8], 18980);
      chk("t4_newbank", cap_d[9], 200);

      // 5: extreme negative coefficients and samples, no wrap
      do_reset();
      for (int k = 0; k < 4; k++) wr_cfg(k, -512, k == 3);
      for (int i = 0; i < 8; i++) send(0, -2048);
      wait_caps(8);
      chk("t5_max", cap_d[7], 8388608);

      // 6: reset during MAC discards the result and restores default coefficients
      do_reset();
      wr_cfg(0, 99, 1'b1);
      send(0, 50);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t6_busy_mac", busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", m_valid, 0);
      chk("t6_rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("t6_no_pulse", m_valid, 0);
      end
      cap_d.delete(); cap_c.delete();
      send(1, 7);
      wait_caps(1);
      chk("t6_default", cap_d[0], 182);
      chk("t6_ch", cap_c[0], 1);

      // Randomized traffic, backpressure and configuration
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         s_valid    = NCH'($urandom);
         din[0]     = DW'($urandom);
         din[1]     = DW'($urandom);
         m_ready    = ($urandom % 4) != 0;
         cfg_we     = ($urandom % 8) == 0;
         cfg_addr   = 2'($urandom);
         cfg_data   = CW'($urandom);
         cfg_commit = ($urandom % 16) == 0;
      end
      @(posedge clk); #1;
      s_valid = '0; cfg_we = 1'b0; cfg_commit = 1'b0; m_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
